loba_mul_seq: RTL and testbench
===============================

Name: loba_mul_seq

Overview:
- Sequential controller for the LOBA approximate multiplier.
- Accepts an operand pair over a valid/ready handshake and splits both operands into high/low K-bit segments using the existing LOBA_SPLIT.
- Time-multiplexes one shared KxK multiplier over 1, 3 or 4 segment-product terms, selected by mode (LOBA0/LOBA1/LOBA2 accuracy).
- Accumulates the shifted terms and returns the 2N-bit product on a valid/ready output handshake.

Parameters:
- N, 16, operand width.
- K, 4, segment width (K < N).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode valid.
- in_ready  out  1  block can accept an operand pair.
- A  in  N  operand A (unsigned).
- B  in  N  operand B (unsigned).
- mode  in  2  0 = hh term only; 1 = hh+hl+lh; 2 = hh+hl+lh+ll; 3 = treated as 2.
- out_valid  out  1  P valid.
- out_ready  in  1  consumer accepts P.
- P  out  2N  approximate product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Split rule per operand X:
  - kh = index of the most-significant 1; sh = kh-(K-1), signed.
  - Xh = X>>sh if sh>=0, else (X<<-sh) truncated to K bits.
  - Residual R = X-(Xh<<sh) if sh>=0, else 0.
  - Xl and sl are derived from R by the same rule; if R==0 then Xl=0 and sl=0.
- Term shift: s = sa+sb. Term = (xa*xb)<<s if s>=0, else (xa*xb)>>(-s).
- Term order: hh, hl (Ah*Bl), lh (Al*Bh), ll.
- Accumulator is 2N bits and cannot overflow, because the sum of terms is <= A*B.
- Reset: state=IDLE; in_ready=0 during rst; out_valid=0; P=0; busy=0; accumulator and term counter cleared. Reset mid-operation aborts with no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register A, B, mode (mode is sampled only here) and go to SPLIT.
  - SPLIT (1 cycle): register Ah, Al, Bh, Bl, sa_h, sa_l, sb_h, sb_l; clear accumulator; term count = 1/3/4 by mode. If A==0 or B==0, go to DONE with P=0.
  - MUL (one cycle per term): the shared multiplier computes the current term; the accumulator adds the shifted term. Terms with zero segments still consume their cycle, so latency is deterministic. After the last term go to DONE.
  - DONE: out_valid=1 and P is held stable. On out_ready, go to IDLE with out_valid=0 in the next cycle. in_ready=0 throughout DONE; no overlap with the next operation.
- Latency (accept edge to first out_valid cycle): mode0 = 3, mode1 = 5, mode2/3 = 6, zero operand = 2.
- Throughput: one result per latency+1 cycles when out_ready is held at 1.
- P changes only on entry to DONE; otherwise it holds its last value.

Decomposition:
- Shared package:
  - mode encodings (MODE_HH=0, MODE_3T=1, MODE_4T=2);
  - state enum (IDLE, SPLIT, MUL, DONE);
  - term-index constants;
  - shift-width constant $clog2(N)+1 (signed).
- Sub-modules:
  - Two LOBA_SPLIT instances (A, B) extended to signed sh/sl outputs, or a new loba_split_s;
  - a loba_term sub-module (KxK multiply plus bidirectional shift), instantiated once and shared.

Test Plan:
- N=16, K=4, mode0, A=0x00F0, B=0x0030 -> P=0x2D00 (11520, exact); out_valid 3 cycles after accept.
- mode0, A=0x1234, B=0x0003 -> P=0x3600 (13824). Same operands with mode1 -> P=0x369C (13980), latency 5. Same operands with mode2 -> 0x369C, latency 6.
- A=0x0001, B=0x0001, mode2 -> P=1 (negative-shift path).
- A=0x0000, B=0x0055, any mode -> P=0, latency 2.
- out_ready held 0 for 4 cycles in DONE -> P, out_valid stable; in_ready=0 and new in_valid ignored; accept on release, in_ready=1 the next cycle.
- rst pulsed during MUL of a mode2 op -> next cycle: IDLE, out_valid=0, P=0, busy=0. Next op (A=0x00F0, B=0x0030) -> 0x2D00.

Source files
------------

// File: rtl/loba_mul_seq_pkg.sv
// Shared definitions for the sequential LOBA multiplier: mode codes,
// controller states, term indices and the signed segment-shift width.
package loba_mul_seq_pkg;

  // Accuracy modes; code 3 behaves like MODE_4T
  localparam logic [1:0] MODE_HH = 2'd0;
  localparam logic [1:0] MODE_3T = 2'd1;
  localparam logic [1:0] MODE_4T = 2'd2;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Term order through the shared multiplier: Ah*Bh, Ah*Bl, Al*Bh, Al*Bl
  localparam logic [1:0] TERM_HH = 2'd0;
  localparam logic [1:0] TERM_HL = 2'd1;
  localparam logic [1:0] TERM_LH = 2'd2;
  localparam logic [1:0] TERM_LL = 2'd3;

  // Number of terms evaluated per mode
  localparam logic [2:0] NTERMS_HH = 3'd1;
  localparam logic [2:0] NTERMS_3T = 3'd3;
  localparam logic [2:0] NTERMS_4T = 3'd4;

  // Signed width holding a segment shift in [-(K-1), N-K]
  function automatic int shift_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/loba_mul_seq_split.sv
// Splits one operand into a high K-bit segment and a low K-bit segment
// taken from the residual, each with a signed shift such that
// x ~= (xh << sh) + (xl << sl). Negative shifts mean the segment was
// left-aligned from a value narrower than K bits.
module loba_mul_seq_split #(
  parameter int N   = 16,
  parameter int K   = 4,
  parameter int SHW = 5
) (
  input  logic [N-1:0]           x,
  output logic [K-1:0]           xh,
  output logic [K-1:0]           xl,
  output logic signed [SHW-1:0]  sh,
  output logic signed [SHW-1:0]  sl
);

  // Leading-one segment of v packed as {shift, segment}; zero maps to all zeros
  function automatic logic [SHW+K-1:0] seg(input logic [N-1:0] v);
    int msb;
    int s;
    logic [N-1:0] t;
    msb = 0;
    t   = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) msb = i;
    end
    s = msb - (K - 1);
    if (v == '0) return '0;
    if (s >= 0) t = v >> s;
    else        t = v << (-s);
    return {s[SHW-1:0], t[K-1:0]};
  endfunction

  logic [SHW+K-1:0] hi_seg;
  logic [SHW+K-1:0] lo_seg;
  logic [N-1:0]     hi_back;
  logic [N-1:0]     resid;

  // High segment, residual left below it, then the low segment of that residual
  always_comb begin
    hi_seg  = seg(x);
    xh      = hi_seg[K-1:0];
    sh      = hi_seg[SHW+K-1:K];
    hi_back = '0;
    resid   = '0;
    if (!sh[SHW-1]) begin
      hi_back = N'(xh) << sh;
      resid   = x - hi_back;
    end
    lo_seg = seg(resid);
    xl     = lo_seg[K-1:0];
    sl     = lo_seg[SHW+K-1:K];
  end

endmodule

// File: rtl/loba_mul_seq_term.sv
// One segment-product term: KxK multiply followed by a shift by the sum
// of the two segment shifts (left when non-negative, right otherwise).
module loba_mul_seq_term #(
  parameter int N   = 16,
  parameter int K   = 4,
  parameter int SHW = 5
) (
  input  logic [K-1:0]          xa,
  input  logic [K-1:0]          xb,
  input  logic signed [SHW-1:0] sa,
  input  logic signed [SHW-1:0] sb,
  output logic [2*N-1:0]        term
);

  logic [2*K-1:0]      prod;
  logic [2*N-1:0]      prod_w;
  logic signed [SHW:0] s;
  logic [SHW:0]        s_mag;

  // Product, combined shift with one guard bit, then bidirectional shift
  always_comb begin
    prod   = xa * xb;
    prod_w = {{(2*N-2*K){1'b0}}, prod};
    s      = {sa[SHW-1], sa} + {sb[SHW-1], sb};
    s_mag  = s[SHW] ? $unsigned(-s) : $unsigned(s);
    term   = s[SHW] ? (prod_w >> s_mag) : (prod_w << s_mag);
  end

endmodule

// File: rtl/loba_mul_seq.sv
// Sequential LOBA approximate multiplier. One operand pair at a time:
// IDLE accepts, SPLIT segments both operands, MUL spends one cycle per
// term on a single shared term unit, DONE presents P until consumed.
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high; valid never depends on ready, and the producer
// holds its data stable while valid is high and ready is low.
module loba_mul_seq
  import loba_mul_seq_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);

  localparam int SHW = shift_width(N);

  state_e                state_q, state_d;
  logic [N-1:0]          a_q, a_d, b_q, b_d;
  logic [1:0]            mode_q, mode_d;
  logic [K-1:0]          ah_q, ah_d, al_q, al_d, bh_q, bh_d, bl_q, bl_d;
  logic signed [SHW-1:0] sah_q, sah_d, sal_q, sal_d, sbh_q, sbh_d, sbl_q, sbl_d;
  logic [2*N-1:0]        acc_q, acc_d, p_q, p_d;
  logic [2:0]            nterms_q, nterms_d;
  logic [1:0]            idx_q, idx_d;

  logic [K-1:0]          sp_ah, sp_al, sp_bh, sp_bl;
  logic signed [SHW-1:0] sp_sah, sp_sal, sp_sbh, sp_sbl;
  logic [K-1:0]          t_xa, t_xb;
  logic signed [SHW-1:0] t_sa, t_sb;
  logic [2*N-1:0]        t_term, acc_sum;
  logic                  accept, zero_op, last_term;

  loba_mul_seq_split #(.N(N), .K(K), .SHW(SHW)) u_split_a (
    .x(a_q), .xh(sp_ah), .xl(sp_al), .sh(sp_sah), .sl(sp_sal)
  );

  loba_mul_seq_split #(.N(N), .K(K), .SHW(SHW)) u_split_b (
    .x(b_q), .xh(sp_bh), .xl(sp_bl), .sh(sp_sbh), .sl(sp_sbl)
  );

  loba_mul_seq_term #(.N(N), .K(K), .SHW(SHW)) u_term (
    .xa(t_xa), .xb(t_xb), .sa(t_sa), .sb(t_sb), .term(t_term)
  );

  assign accept    = in_valid && in_ready;
  assign zero_op   = (a_q == '0) || (b_q == '0);
  assign last_term = (({1'b0, idx_q}) + 3'd1) == nterms_q;
  assign acc_sum   = acc_q + t_term;

  // Route the segments of the current term to the shared term unit
  always_comb begin
    t_xa = ah_q;
    t_sa = sah_q;
    t_xb = bh_q;
    t_sb = sbh_q;
    case (idx_q)
      TERM_HL: begin t_xb = bl_q; t_sb = sbl_q; end
      TERM_LH: begin t_xa = al_q; t_sa = sal_q; end
      TERM_LL: begin
        t_xa = al_q; t_sa = sal_q;
        t_xb = bl_q; t_sb = sbl_q;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SPLIT;
      SPLIT:   state_d = zero_op ? DONE : MUL;
      MUL:     if (last_term) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture, segment, accumulate, publish P on entry to DONE
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    ah_d     = ah_q;
    al_d     = al_q;
    bh_d     = bh_q;
    bl_d     = bl_q;
    sah_d    = sah_q;
    sal_d    = sal_q;
    sbh_d    = sbh_q;
    sbl_d    = sbl_q;
    acc_d    = acc_q;
    p_d      = p_q;
    nterms_d = nterms_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = A;
          b_d    = B;
          mode_d = mode;
        end
      end
      SPLIT: begin
        ah_d  = sp_ah;
        al_d  = sp_al;
        bh_d  = sp_bh;
        bl_d  = sp_bl;
        sah_d = sp_sah;
        sal_d = sp_sal;
        sbh_d = sp_sbh;
        sbl_d = sp_sbl;
        acc_d = '0;
        idx_d = TERM_HH;
        case (mode_q)
          MODE_HH: nterms_d = NTERMS_HH;
          MODE_3T: nterms_d = NTERMS_3T;
          default: nterms_d = NTERMS_4T;
        endcase
        if (zero_op) p_d = '0;
      end
      MUL: begin
        acc_d = acc_sum;
        idx_d = idx_q + 2'd1;
        if (last_term) p_d = acc_sum;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the state; in_ready is suppressed while reset is held
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    P         = p_q;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      ah_q     <= '0;
      al_q     <= '0;
      bh_q     <= '0;
      bl_q     <= '0;
      sah_q    <= '0;
      sal_q    <= '0;
      sbh_q    <= '0;
      sbl_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      nterms_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      ah_q     <= ah_d;
      al_q     <= al_d;
      bh_q     <= bh_d;
      bl_q     <= bl_d;
      sah_q    <= sah_d;
      sal_q    <= sal_d;
      sbh_q    <= sbh_d;
      sbl_q    <= sbl_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      nterms_q <= nterms_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_loba_mul_seq.sv
// Bench for loba_mul_seq: directed operand pairs with hand-computed
// products, a behavioural LOBA model for extra pairs, and one compare
// process checking P, latency and handshake behaviour every cycle.
module tb_loba_mul_seq;

  localparam int N = 16;
  localparam int K = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [1:0]     mode = 2'd0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*N-1:0] P;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_cyc_q[$];
  logic [2*N-1:0] last_p = '0;
  logic           prev_ov = 1'b0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [1:0]     m;
    logic [2*N-1:0] p;
  } vec_t;

  loba_mul_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic void split_m(input longint x, output longint seg, output int sh);
    int k;
    k = 0;
    seg = 0;
    sh = 0;
    if (x == 0) return;
    while ((longint'(1) << (k + 1)) <= x) k++;
    sh = k - (K - 1);
    if (sh >= 0) seg = x / (longint'(1) << sh);
    else seg = (x * (longint'(1) << -sh)) % (longint'(1) << K);
  endfunction

  function automatic longint term_m(input longint x, input longint y, input int s);
    if (s >= 0) return (x * y) * (longint'(1) << s);
    return (x * y) / (longint'(1) << -s);
  endfunction

  function automatic longint model(input longint a, input longint b, input int m);
    longint ah, al, bh, bl, ra, rb, sum;
    int sah, sal, sbh, sbl;
    if (a == 0 || b == 0) return 0;
    split_m(a, ah, sah);
    ra = (sah >= 0) ? a - ah * (longint'(1) << sah) : 0;
    split_m(ra, al, sal);
    split_m(b, bh, sbh);
    rb = (sbh >= 0) ? b - bh * (longint'(1) << sbh) : 0;
    split_m(rb, bl, sbl);
    sum = term_m(ah, bh, sah + sbh);
    if (m >= 1) sum += term_m(ah, bl, sah + sbl) + term_m(al, bh, sal + sbh);
    if (m >= 2) sum += term_m(al, bl, sal + sbl);
    return sum;
  endfunction

  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m);
    if (a == 0 || b == 0) return 2;
    if (m == 2'd0) return 3;
    if (m == 2'd1) return 5;
    return 6;
  endfunction

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      acc_cyc_q.delete();
      last_p  = '0;
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("P", 64'(P), 64'(exp_q[0]));
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!prev_ov) check("latency", 64'(cyc - acc_cyc_q[0]), 64'(lat_q[0]));
          if (out_ready) begin
            last_p = exp_q.pop_front();
            void'(lat_q.pop_front());
            void'(acc_cyc_q.pop_front());
          end
        end
      end else begin
        check("P_hold", 64'(P), 64'(last_p));
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m,
                      input logic [2*N-1:0] exp_p, input bit expect_out);
    int n;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    mode = m;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
    end else if (expect_out) begin
      exp_q.push_back(exp_p);
      lat_q.push_back(exp_lat(a, b, m));
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("done_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[9];
  logic [N-1:0] ext_a[4];
  logic [N-1:0] ext_b[4];
  logic [1:0]   ext_m[4];

  initial begin
    int n;
    vecs[0] = '{16'h00F0, 16'h0030, 2'd0, 32'h2D00};
    vecs[1] = '{16'h1234, 16'h0003, 2'd0, 32'h3600};
    vecs[2] = '{16'h1234, 16'h0003, 2'd1, 32'h369C};
    vecs[3] = '{16'h1234, 16'h0003, 2'd2, 32'h369C};
    vecs[4] = '{16'h1234, 16'h0003, 2'd3, 32'h369C};
    vecs[5] = '{16'h0001, 16'h0001, 2'd2, 32'h0001};
    vecs[6] = '{16'h0000, 16'h0055, 2'd0, 32'h0000};
    vecs[7] = '{16'h0000, 16'h0055, 2'd2, 32'h0000};
    vecs[8] = '{16'h0055, 16'h0000, 2'd1, 32'h0000};
    ext_a = '{16'hFFFF, 16'h8001, 16'h0013, 16'h00F0};
    ext_b = '{16'hFFFF, 16'h7FFE, 16'h0300, 16'h0030};
    ext_m = '{2'd2, 2'd1, 2'd2, 2'd2};

    // model pinned against hand-computed products
    check("model_f0x30_m0", 64'(model(64'h00F0, 64'h0030, 0)), 64'h2D00);
    check("model_1234x3_m0", 64'(model(64'h1234, 64'h0003, 0)), 64'h3600);
    check("model_1234x3_m1", 64'(model(64'h1234, 64'h0003, 1)), 64'h369C);
    check("model_1x1_m2", 64'(model(64'h0001, 64'h0001, 2)), 64'h0001);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_P", 64'(P), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].p, 1'b1);
      if (i == 0) begin
        @(negedge clk);
        check("busy_in_split", 64'(busy), 64'd1);
      end
      wait_done();
    end

    // further pairs checked against the model
    for (int i = 0; i < 4; i++) begin
      send(ext_a[i], ext_b[i], ext_m[i], 32'(model(64'(ext_a[i]), 64'(ext_b[i]), int'(ext_m[i]))), 1'b1);
      wait_done();
    end

    // back-pressure in DONE: result held, new request ignored
    out_ready = 1'b0;
    send(16'h00F0, 16'h0030, 2'd0, 32'h2D00, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", 64'(out_valid), 64'd1);
    A = 16'h1234;
    B = 16'h0003;
    mode = 2'd1;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_busy", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    send(16'h1234, 16'h0003, 2'd1, 32'h369C, 1'b1);
    wait_done();

    // reset during MUL aborts the operation
    send(16'h1234, 16'h0003, 2'd2, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_P", 64'(P), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    send(16'h00F0, 16'h0030, 2'd0, 32'h2D00, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
